// File: rtl/hbus_cfg_master_pkg.sv
// Shared HBUS widths, controller state encoding and router register map.
// Imported by the arbiter and the top-level controller.
package hbus_cfg_pkg;

  localparam int HBUS_ADDR_W = 16;
  localparam int HBUS_DATA_W = 8;

  localparam logic [HBUS_ADDR_W-1:0] ROUTER_MAXPKT = 16'h1000;
  localparam logic [HBUS_ADDR_W-1:0] ROUTER_EN     = 16'h1001;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    WAIT = 2'd2
  } state_e;

  // Width of a requester index / round-robin pointer for n requesters.
  function automatic int ptr_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/hbus_cfg_master_rr_arbiter.sv
// Combinational round-robin arbiter: the first asserted request at or after
// ptr_i (wrapping) wins. Produces a one-hot grant plus its index.
module rr_arbiter
  import hbus_cfg_pkg::*;
#(
  parameter int N = 3,
  localparam int PW = ptr_w(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  input  logic          enable_i,
  output logic [N-1:0]  grant_o,
  output logic [PW-1:0] grant_idx_o,
  output logic          grant_valid_o
);

  int j;

  // Scan from the farthest offset down so the nearest request to ptr_i
  // is the last (winning) assignment.
  always_comb begin
    grant_o       = '0;
    grant_idx_o   = '0;
    grant_valid_o = 1'b0;
    j             = 0;
    for (int k = N - 1; k >= 0; k--) begin
      j = int'(ptr_i) + k;
      if (j >= N) begin
        j = j - N;
      end
      if (enable_i && req_i[j]) begin
        grant_o       = '0;
        grant_o[j]    = 1'b1;
        grant_idx_o   = PW'(j);
        grant_valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/hbus_cfg_master.sv
// Multi-requester HBUS configuration host: round-robin arbitration of
// single-byte register commands serialized into fixed-timing HBUS cycles.
module hbus_cfg_master
  import hbus_cfg_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int RD_LAT  = 1
) (
  input  logic                           clock_i,
  input  logic                           reset_i,
  input  logic [NUM_REQ-1:0]             req_valid_i,
  output logic [NUM_REQ-1:0]             req_ready_o,
  input  logic [NUM_REQ-1:0]             req_wr_i,
  input  logic [NUM_REQ*HBUS_ADDR_W-1:0] req_addr_i,
  input  logic [NUM_REQ*HBUS_DATA_W-1:0] req_wdata_i,
  output logic [NUM_REQ-1:0]             rsp_valid_o,
  output logic [HBUS_DATA_W-1:0]         rsp_rdata_o,
  output logic [HBUS_ADDR_W-1:0]         haddr_o,
  output logic [HBUS_DATA_W-1:0]         hdata_w_o,
  input  logic [HBUS_DATA_W-1:0]         hdata_r_i,
  output logic                           hen_o,
  output logic                           hwr_rd_o,
  output logic                           busy_o
);

  localparam int PW = ptr_w(NUM_REQ);
  localparam int CW = 2;

  state_e                 state_q, state_d;
  logic [PW-1:0]          ptr_q, ptr_d;
  logic [PW-1:0]          gidx_q, gidx_d;
  logic                   wr_q, wr_d;
  logic [HBUS_ADDR_W-1:0] addr_q, addr_d;
  logic [HBUS_DATA_W-1:0] wdata_q, wdata_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [NUM_REQ-1:0]     rsp_valid_q, rsp_valid_d;
  logic [HBUS_DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;

  logic [NUM_REQ-1:0] grant;
  logic [PW-1:0]      grant_idx;
  logic               grant_valid;

  rr_arbiter #(
    .N(NUM_REQ)
  ) u_arb (
    .req_i        (req_valid_i),
    .ptr_i        (ptr_q),
    .enable_i     (state_q == IDLE),
    .grant_o      (grant),
    .grant_idx_o  (grant_idx),
    .grant_valid_o(grant_valid)
  );

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      gidx_q      <= '0;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cnt_q       <= '0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      gidx_q      <= gidx_d;
      wr_q        <= wr_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    gidx_d      = gidx_q;
    wr_d        = wr_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cnt_d       = cnt_q;
    rsp_valid_d = '0;
    rsp_rdata_d = rsp_rdata_q;

    unique case (state_q)
      IDLE: begin
        if (grant_valid) begin
          gidx_d  = grant_idx;
          wr_d    = req_wr_i[grant_idx];
          addr_d  = req_addr_i[HBUS_ADDR_W*grant_idx +: HBUS_ADDR_W];
          wdata_d = req_wdata_i[HBUS_DATA_W*grant_idx +: HBUS_DATA_W];
          ptr_d   = (grant_idx == PW'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
          state_d = CMD;
        end
      end
      CMD: begin
        if (wr_q) begin
          rsp_valid_d[gidx_q] = 1'b1;
          state_d             = IDLE;
        end else begin
          cnt_d   = CW'(RD_LAT - 1);
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          rsp_rdata_d         = hdata_r_i;
          rsp_valid_d[gidx_q] = 1'b1;
          state_d             = IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Bus fields come straight from the command registers, which only change
  // on a grant, so they hold steady outside the enable cycle.
  assign req_ready_o = grant;
  assign hen_o       = (state_q == CMD);
  assign haddr_o     = addr_q;
  assign hdata_w_o   = wdata_q;
  assign hwr_rd_o    = wr_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_hbus_cfg_master.sv
// Scoreboard bench for hbus_cfg_master: directed commands push expected HBUS
// cycles and completions; a negedge monitor pops and compares them.
module tb_hbus_cfg_master;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // DUT0: RD_LAT=1, DUT1: RD_LAT=3
  logic        reset0, reset1;
  logic [2:0]  valid0, valid1, ready0, ready1, wr0, wr1, rv0, rv1;
  logic [47:0] addr0, addr1;
  logic [23:0] wdata0, wdata1;
  logic [7:0]  rdata0, rdata1, hdw0, hdw1, hdr0, hdr1;
  logic [15:0] haddr0, haddr1;
  logic        hen0, hen1, hwr0, hwr1, busy0, busy1;

  hbus_cfg_master #(.NUM_REQ(3), .RD_LAT(1)) u_dut0 (
    .clock_i(clk), .reset_i(reset0),
    .req_valid_i(valid0), .req_ready_o(ready0), .req_wr_i(wr0),
    .req_addr_i(addr0), .req_wdata_i(wdata0),
    .rsp_valid_o(rv0), .rsp_rdata_o(rdata0),
    .haddr_o(haddr0), .hdata_w_o(hdw0), .hdata_r_i(hdr0),
    .hen_o(hen0), .hwr_rd_o(hwr0), .busy_o(busy0)
  );

  hbus_cfg_master #(.NUM_REQ(3), .RD_LAT(3)) u_dut1 (
    .clock_i(clk), .reset_i(reset1),
    .req_valid_i(valid1), .req_ready_o(ready1), .req_wr_i(wr1),
    .req_addr_i(addr1), .req_wdata_i(wdata1),
    .rsp_valid_o(rv1), .rsp_rdata_o(rdata1),
    .haddr_o(haddr1), .hdata_w_o(hdw1), .hdata_r_i(hdr1),
    .hen_o(hen1), .hwr_rd_o(hwr1), .busy_o(busy1)
  );

  typedef struct {
    int          dut;
    int          cyc;
    logic [15:0] addr;
    logic        wr;
    logic [7:0]  data;
  } hen_exp_t;

  typedef struct {
    int         dut;
    int         cyc;
    int         idx;
    logic       rd;
    logic [7:0] rdata;
  } rsp_exp_t;

  hen_exp_t hen_q[$];
  rsp_exp_t rsp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  task automatic exp_hen(input int d, input int c, input logic [15:0] a,
                         input logic w, input logic [7:0] wd);
    hen_exp_t e;
    e.dut = d; e.cyc = c; e.addr = a; e.wr = w; e.data = wd;
    hen_q.push_back(e);
  endtask

  task automatic exp_rsp(input int d, input int c, input int i,
                         input logic rd, input logic [7:0] rdv);
    rsp_exp_t e;
    e.dut = d; e.cyc = c; e.idx = i; e.rd = rd; e.rdata = rdv;
    rsp_q.push_back(e);
  endtask

  task automatic mon(input int d, input logic hen, input logic [15:0] a,
                     input logic w, input logic [7:0] wd,
                     input logic [2:0] rv, input logic [7:0] rd);
    hen_exp_t he;
    rsp_exp_t re;
    logic [2:0] req_rv;
    if (hen) begin
      n_cmp++;
      if (hen_q.size() == 0) begin
        n_err++;
        $display("FAIL hen_unexpected dut%0d cyc %0d: got addr %h wr %0b, required no hen", d, cyc, a, w);
      end else begin
        he = hen_q.pop_front();
        if (he.dut != d || he.cyc != cyc || he.addr != a || he.wr != w || (w && he.data != wd)) begin
          n_err++;
          $display("FAIL hen dut%0d: got cyc %0d addr %h wr %0b wdata %h, required dut%0d cyc %0d addr %h wr %0b wdata %h",
                   d, cyc, a, w, wd, he.dut, he.cyc, he.addr, he.wr, he.data);
        end else begin
          $display("hen  ok dut%0d cyc %0d addr %h wr %0b wdata %h", d, cyc, a, w, wd);
        end
      end
    end
    if (rv != 3'b000) begin
      n_cmp++;
      if (rsp_q.size() == 0) begin
        n_err++;
        $display("FAIL rsp_unexpected dut%0d cyc %0d: got rsp_valid %b, required none", d, cyc, rv);
      end else begin
        re = rsp_q.pop_front();
        req_rv = '0;
        req_rv[re.idx] = 1'b1;
        if (re.dut != d || re.cyc != cyc || rv != req_rv || (re.rd && rd != re.rdata)) begin
          n_err++;
          $display("FAIL rsp dut%0d: got cyc %0d rsp_valid %b rdata %h, required dut%0d cyc %0d rsp_valid %b rdata %h",
                   d, cyc, rv, rd, re.dut, re.cyc, req_rv, re.rdata);
        end else begin
          $display("rsp  ok dut%0d cyc %0d rsp_valid %b rdata %h", d, cyc, rv, rd);
        end
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0, hen0, haddr0, hwr0, hdw0, rv0, rdata0);
    mon(1, hen1, haddr1, hwr1, hdw1, rv1, rdata1);
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
    n_cmp++;
    if (got !== req) begin
      n_err++;
      $display("FAIL %s cyc %0d: got %h, required %h", name, cyc, got, req);
    end else begin
      $display("chk  ok %s cyc %0d = %h", name, cyc, got);
    end
  endtask

  // Requesters drop valid after the edge on which their handshake happened.
  task automatic tick(input int n = 1);
    logic [2:0] hs0, hs1;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      hs0 = valid0 & ready0;
      hs1 = valid1 & ready1;
      @(posedge clk);
      #1;
      valid0 = valid0 & ~hs0;
      valid1 = valid1 & ~hs1;
    end
  endtask

  task automatic issue(input int d, input int i, input logic w,
                       input logic [15:0] a, input logic [7:0] wd);
    if (d == 0) begin
      valid0[i] = 1'b1; wr0[i] = w; addr0[16*i +: 16] = a; wdata0[8*i +: 8] = wd;
    end else begin
      valid1[i] = 1'b1; wr1[i] = w; addr1[16*i +: 16] = a; wdata1[8*i +: 8] = wd;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, required end of test");
    $fatal(1, "watchdog");
  end

  int t;

  initial begin
    reset0 = 1'b1; reset1 = 1'b1;
    valid0 = '0; valid1 = '0; wr0 = '0; wr1 = '0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    hdr0 = 8'h00; hdr1 = 8'hEE;
    tick(2);
    chk("rst_hen", 32'(hen0), 32'h0);
    chk("rst_hwr_rd", 32'(hwr0), 32'h0);
    chk("rst_haddr", 32'(haddr0), 32'h0);
    chk("rst_hdata_w", 32'(hdw0), 32'h0);
    chk("rst_rsp_valid", 32'(rv0), 32'h0);
    chk("rst_rsp_rdata", 32'(rdata0), 32'h0);
    chk("rst_busy", 32'(busy0), 32'h0);
    chk("rst_busy_d1", 32'(busy1), 32'h0);
    reset0 = 1'b0; reset1 = 1'b0;
    tick(1);

    // Single write from requester 0
    t = cyc;
    issue(0, 0, 1'b1, 16'h1000, 8'h3F);
    exp_hen(0, t + 1, 16'h1000, 1'b1, 8'h3F);
    exp_rsp(0, t + 2, 0, 1'b0, 8'h00);
    #1 chk("wr_ready", 32'(ready0), 32'h1);
    tick(3);

    // Read from requester 1, RD_LAT=1
    hdr0 = 8'h01;
    t = cyc;
    issue(0, 1, 1'b0, 16'h1001, 8'h00);
    exp_hen(0, t + 1, 16'h1001, 1'b0, 8'h00);
    exp_rsp(0, t + 3, 1, 1'b1, 8'h01);
    tick(4);
    chk("hold_haddr", 32'(haddr0), 32'h1001);
    chk("hold_hen", 32'(hen0), 32'h0);

    // Three simultaneous writes right after reset
    reset0 = 1'b1;
    tick(1);
    reset0 = 1'b0;
    t = cyc;
    issue(0, 0, 1'b1, 16'h2000, 8'hA0);
    issue(0, 1, 1'b1, 16'h2001, 8'hA1);
    issue(0, 2, 1'b1, 16'h2002, 8'hA2);
    exp_hen(0, t + 1, 16'h2000, 1'b1, 8'hA0);
    exp_rsp(0, t + 2, 0, 1'b0, 8'h00);
    exp_hen(0, t + 3, 16'h2001, 1'b1, 8'hA1);
    exp_rsp(0, t + 4, 1, 1'b0, 8'h00);
    exp_hen(0, t + 5, 16'h2002, 1'b1, 8'hA2);
    exp_rsp(0, t + 6, 2, 1'b0, 8'h00);
    #1 chk("multi_ready", 32'(ready0), 32'h1);
    tick(8);

    // Requester 2 alone, then 0 and 2 together: pointer wraps to 0
    hdr0 = 8'hA5;
    t = cyc;
    issue(0, 2, 1'b1, 16'h3002, 8'h55);
    exp_hen(0, t + 1, 16'h3002, 1'b1, 8'h55);
    exp_rsp(0, t + 2, 2, 1'b0, 8'h00);
    tick(1);
    issue(0, 0, 1'b0, 16'h3000, 8'h00);
    issue(0, 2, 1'b1, 16'h3002, 8'h66);
    exp_hen(0, t + 3, 16'h3000, 1'b0, 8'h00);
    exp_rsp(0, t + 5, 0, 1'b1, 8'hA5);
    exp_hen(0, t + 6, 16'h3002, 1'b1, 8'h66);
    exp_rsp(0, t + 7, 2, 1'b0, 8'h00);
    #1 chk("cmd_ready_low", 32'(ready0), 32'h0);
    tick(8);

    // Reset during WAIT of a read discards it
    t = cyc;
    issue(0, 1, 1'b0, 16'h1001, 8'h00);
    exp_hen(0, t + 1, 16'h1001, 1'b0, 8'h00);
    tick(2);
    reset0 = 1'b1;
    #1;
    chk("midrst_hen", 32'(hen0), 32'h0);
    chk("midrst_busy", 32'(busy0), 32'h0);
    chk("midrst_rsp", 32'(rv0), 32'h0);
    tick(1);
    reset0 = 1'b0;
    t = cyc;
    issue(0, 0, 1'b1, 16'h4000, 8'h11);
    issue(0, 2, 1'b1, 16'h4002, 8'h22);
    exp_hen(0, t + 1, 16'h4000, 1'b1, 8'h11);
    exp_rsp(0, t + 2, 0, 1'b0, 8'h00);
    exp_hen(0, t + 3, 16'h4002, 1'b1, 8'h22);
    exp_rsp(0, t + 4, 2, 1'b0, 8'h00);
    #1 chk("postrst_ready", 32'(ready0), 32'h1);
    tick(6);

    // RD_LAT=3 read; hdata_r carries the value only in the sampling cycle
    t = cyc;
    issue(1, 1, 1'b0, 16'h1000, 8'h00);
    exp_hen(1, t + 1, 16'h1000, 1'b0, 8'h00);
    exp_rsp(1, t + 5, 1, 1'b1, 8'h20);
    tick(1);
    issue(1, 0, 1'b1, 16'h5000, 8'h77);
    for (int k = 1; k <= 4; k++) begin
      if (k == 4) hdr1 = 8'h20;
      #1 chk($sformatf("lat3_ready_t%0d", k), 32'(ready1), 32'h0);
      tick(1);
    end
    hdr1 = 8'hEE;
    exp_hen(1, t + 6, 16'h5000, 1'b1, 8'h77);
    exp_rsp(1, t + 7, 0, 1'b0, 8'h00);
    #1 chk("lat3_ready_t5", 32'(ready1), 32'h1);
    tick(4);
    chk("lat3_rdata_hold", 32'(rdata1), 32'h20);

    tick(2);
    chk("hen_queue_empty", 32'(hen_q.size()), 32'h0);
    chk("rsp_queue_empty", 32'(rsp_q.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
